// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-addressed memory access controller.
package mem_ctrl_pkg;

  localparam int MEM_AW = 21;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [1:0]        offset;
    logic [MEM_AW-1:0] waddr;
    logic [31:0]       wdata;
  } req_t;

  // Reserved size 11 is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00) || (size == 2'b11);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = '0;
    lane_h     = '0;
    load_val   = word;
    store_word = wdata;
    case (size)
      SZ_BYTE: begin
        lane_b     = word[{offset, 3'b000} +: 8];
        load_val   = {{24{sign_ext & lane_b[7]}}, lane_b};
        store_word = word;
        store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        lane_h     = offset[1] ? word[31:16] : word[15:0];
        load_val   = {{16{sign_ext & lane_h[15]}}, lane_h};
        store_word = word;
        store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_val   = word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_ctrl_8m.sv
// Byte/half/word load-store controller over a 32-bit word memory; sub-word stores use RMW.
// Optional performance counters are enabled with `define MEMCTRL_PERF_EN.
module mem_ctrl_8m
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              busy,
  output logic              misalign,
  output logic [MEM_AW-1:0] mem_dira,
  output logic [31:0]       mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  input  logic [31:0]       mem_out
`ifdef MEMCTRL_PERF_EN
  ,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_rmw
`endif
);

  localparam logic [1:0] WCNT_INIT = 2'(MEM_LATENCY - 1);

  state_t      state, nxt;
  req_t        rq;
  logic [31:0] cap_word;
  logic [1:0]  wcnt;
  logic        mis_in;
  logic        wait_last;
  logic [31:0] align_word, load_val, store_word;

  assign mis_in    = is_misaligned(size, addr[1:0]);
  assign wait_last = (state == ST_WAIT) && (wcnt == 2'd0);

  // Read data is extracted straight from mem_out on the capture cycle so rdata is valid in DONE.
  assign align_word = (state == ST_WAIT) ? mem_out : cap_word;

  mem_lane_align u_align (
    .word       (align_word),
    .offset     (rq.offset),
    .size       (rq.size),
    .sign_ext   (rq.sign_ext),
    .wdata      (rq.wdata),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (req) nxt = mis_in ? ST_DONE : (we && size == SZ_WORD) ? ST_WRITE : ST_READ;
      ST_READ:  nxt = ST_WAIT;
      ST_WAIT:  if (wcnt == 2'd0) nxt = rq.we ? ST_WRITE : ST_DONE;
      ST_WRITE: nxt = ST_DONE;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rq       <= '0;
      cap_word <= '0;
      wcnt     <= '0;
      rdata    <= '0;
      misalign <= 1'b0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && req) begin
        rq       <= '{we: we, size: size, sign_ext: sign_ext, offset: addr[1:0],
                      waddr: addr[MEM_AW+1:2], wdata: wdata};
        misalign <= mis_in;
      end
      if (state == ST_READ) wcnt <= WCNT_INIT;
      else if (state == ST_WAIT && wcnt != 2'd0) wcnt <= wcnt - 2'd1;
      if (wait_last) begin
        cap_word <= mem_out;
        if (!rq.we) rdata <= load_val;
      end
    end
  end

  assign busy           = (state != ST_IDLE);
  assign ready          = (state == ST_DONE);
  assign mem_memread    = (state == ST_READ);
  assign mem_memwrite   = (state == ST_WRITE);
  assign mem_dira       = rq.waddr;
  assign mem_write_data = (rq.size == SZ_WORD) ? rq.wdata : store_word;

`ifdef MEMCTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_rmw    <= '0;
    end else if (state == ST_DONE && !misalign) begin
      if (!rq.we) perf_loads <= perf_loads + 32'd1;
      if (rq.we) perf_stores <= perf_stores + 32'd1;
      if (rq.we && rq.size != SZ_WORD) perf_rmw <= perf_rmw + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_ctrl_8m.sv
// Directed bench for mem_ctrl_8m: one DUT at MEM_LATENCY=1, one at MEM_LATENCY=3, each with a word memory.
module tb_mem_ctrl_8m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [22:0] addr = '0;
  logic [31:0] wdata = '0;
  bit          sel = 1'b0;

  logic [31:0] rdata_a, rdata_b, wd_a, wd_b, mo_a, mo_b, pend_b;
  logic        ready_a, ready_b, busy_a, busy_b, mis_a, mis_b, mw_a, mw_b, mr_a, mr_b;
  logic [20:0] dira_a, dira_b;
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  int          cnt_b = 0;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  mem_ctrl_8m #(.ADDR_W(23), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata_a), .ready(ready_a), .busy(busy_a),
    .misalign(mis_a), .mem_dira(dira_a), .mem_write_data(wd_a), .mem_memwrite(mw_a),
    .mem_memread(mr_a), .mem_out(mo_a));

  mem_ctrl_8m #(.ADDR_W(23), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata_b), .ready(ready_b), .busy(busy_b),
    .misalign(mis_b), .mem_dira(dira_b), .mem_write_data(wd_b), .mem_memwrite(mw_b),
    .mem_memread(mr_b), .mem_out(mo_b));

  // Latency-1 memory: data registered on the strobe edge.
  always @(posedge clk) begin
    if (mw_a) mem_a[dira_a[3:0]] <= wd_a;
    if (mr_a) mo_a <= mem_a[dira_a[3:0]];
  end

  // Latency-3 memory: garbage on the bus until the data is due.
  always @(posedge clk) begin
    if (mw_b) mem_b[dira_b[3:0]] <= wd_b;
    if (mr_b) begin
      pend_b <= mem_b[dira_b[3:0]];
      cnt_b  <= 2;
      mo_b   <= 32'hBAD0BAD0;
    end else if (cnt_b != 0) begin
      cnt_b <= cnt_b - 1;
      if (cnt_b == 1) mo_b <= pend_b;
    end
  end

  wire        s_ready = sel ? ready_b : ready_a;
  wire        s_mr    = sel ? mr_b : mr_a;
  wire        s_mw    = sel ? mw_b : mw_a;
  wire        s_mis   = sel ? mis_b : mis_a;
  wire [31:0] s_rdata = sel ? rdata_b : rdata_a;
  wire [31:0] s_wd    = sel ? wd_b : wd_a;
  wire [20:0] s_dira  = sel ? dira_b : dira_a;

  // Issues one request and returns the req->ready latency (-1 if no ready within 20 cycles).
  task automatic do_req(input bit s, input bit hold, input bit w, input logic [1:0] sz,
                        input bit sx, input logic [22:0] a, input logic [31:0] d,
                        output int lat, output int nrd, output int nwr, output logic [31:0] wdo,
                        output logic [20:0] dio, output logic [31:0] rdo, output logic miso);
    bit found = 0;
    lat = -1; nrd = 0; nwr = 0; wdo = '0; dio = '0; rdo = '0; miso = 1'b0;
    @(negedge clk);
    sel = s; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    if (s) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin req_a = 1'b0; req_b = 1'b0; end
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      if (s_mr) nrd++;
      if (s_mw) begin nwr++; wdo = s_wd; dio = s_dira; end
      if (s_ready) begin found = 1; lat = c; rdo = s_rdata; miso = s_mis; end
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if ({rdata_a, wd_a} !== 64'h0) begin fails++; $display("FAIL reset_data got %h exp 0", {rdata_a, wd_a}); end
    tests++; if ({ready_a, busy_a, mis_a, mw_a, mr_a, dira_a} !== 26'h0) begin fails++; $display("FAIL reset_ctrl got %h exp 0", {ready_a, busy_a, mis_a, mw_a, mr_a, dira_a}); end
    rst = 1'b0;
  endtask

  task automatic test_word();
    int lat, nr, nw; logic [31:0] wd, rd; logic [20:0] di; logic m;
    do_req(0, 0, 1, 2'b10, 0, 23'h10, 32'hDEADBEEF, lat, nr, nw, wd, di, rd, m);
    tests++; if (lat !== 2) begin fails++; $display("FAIL wst_lat got %0d exp 2", lat); end
    tests++; if ({nr, nw} !== {32'd0, 32'd1}) begin fails++; $display("FAIL wst_strobes got rd=%0d wr=%0d exp 0/1", nr, nw); end
    tests++; if ({di, wd} !== {21'h4, 32'hDEADBEEF}) begin fails++; $display("FAIL wst_data got %h/%h exp 4/deadbeef", di, wd); end
    do_req(0, 0, 0, 2'b10, 0, 23'h10, 32'h0, lat, nr, nw, wd, di, rd, m);
    tests++; if (lat !== 3) begin fails++; $display("FAIL wld_lat got %0d exp 3", lat); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL wld_data got %h exp deadbeef", rd); end
    tests++; if ({nr, nw} !== {32'd1, 32'd0}) begin fails++; $display("FAIL wld_strobes got rd=%0d wr=%0d exp 1/0", nr, nw); end
  endtask

  task automatic test_byte_rmw();
    int lat, nr, nw; logic [31:0] wd, rd; logic [20:0] di; logic m;
    do_req(0, 0, 1, 2'b10, 0, 23'h20, 32'h11223344, lat, nr, nw, wd, di, rd, m);
    do_req(0, 0, 1, 2'b00, 0, 23'h21, 32'hFFFFFFAA, lat, nr, nw, wd, di, rd, m);
    tests++; if (lat !== 4) begin fails++; $display("FAIL rmw_lat got %0d exp 4", lat); end
    tests++; if ({nr, nw} !== {32'd1, 32'd1}) begin fails++; $display("FAIL rmw_strobes got rd=%0d wr=%0d exp 1/1", nr, nw); end
    tests++; if (wd !== 32'h1122AA44) begin fails++; $display("FAIL rmw_wdata got %h exp 1122aa44", wd); end
    tests++; if (mem_a[8] !== 32'h1122AA44) begin fails++; $display("FAIL rmw_mem got %h exp 1122aa44", mem_a[8]); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rmw_rdata_hold got %h exp deadbeef", rd); end
  endtask

  task automatic test_signed();
    int lat, nr, nw; logic [31:0] wd, rd; logic [20:0] di; logic m;
    logic [22:0] la [6] = '{23'h32, 23'h32, 23'h32, 23'h30, 23'h33, 23'h30};
    logic [1:0]  ls [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    bit          lx [6] = '{1, 0, 1, 0, 1, 1};
    logic [31:0] le [6] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0, 32'h00007F01, 32'hFFFFFF80, 32'h80F07F01};
    do_req(0, 0, 1, 2'b10, 0, 23'h30, 32'h80F07F01, lat, nr, nw, wd, di, rd, m);
    for (int i = 0; i < 6; i++) begin
      do_req(0, 0, 0, ls[i], lx[i], la[i], 32'h0, lat, nr, nw, wd, di, rd, m);
      tests++; if (rd !== le[i]) begin fails++; $display("FAIL ext_load[%0d] got %h exp %h", i, rd, le[i]); end
    end
  endtask

  task automatic test_misalign();
    int lat, nr, nw; logic [31:0] wd, rd; logic [20:0] di; logic m;
    logic [22:0] ma [3] = '{23'h3, 23'h2, 23'h0};
    logic [1:0]  ms [3] = '{2'b01, 2'b10, 2'b11};
    bit          mw [3] = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      do_req(0, 0, mw[i], ms[i], 1, ma[i], 32'h12345678, lat, nr, nw, wd, di, rd, m);
      tests++; if ({lat, nr, nw} !== {32'd1, 32'd0, 32'd0}) begin fails++; $display("FAIL mis_lat_strobes[%0d] got lat=%0d rd=%0d wr=%0d exp 1/0/0", i, lat, nr, nw); end
      tests++; if ({m, rd} !== {1'b1, 32'h80F07F01}) begin fails++; $display("FAIL mis_flag_rdata[%0d] got %b/%h exp 1/80f07f01", i, m, rd); end
    end
    do_req(0, 0, 0, 2'b01, 0, 23'h30, 32'h0, lat, nr, nw, wd, di, rd, m);
    tests++; if ({m, rd} !== {1'b0, 32'h00007F01}) begin fails++; $display("FAIL mis_clear got %b/%h exp 0/00007f01", m, rd); end
  endtask

  task automatic test_busy_reset();
    int lat, nr, nw; logic [31:0] wd, rd; logic [20:0] di; logic m;
    bit wr_seen = 0;
    do_req(0, 1, 1, 2'b01, 0, 23'h22, 32'h0000BEEF, lat, nr, nw, wd, di, rd, m);
    tests++; if ({lat, nr, nw} !== {32'd4, 32'd1, 32'd1}) begin fails++; $display("FAIL busy_hold got lat=%0d rd=%0d wr=%0d exp 4/1/1", lat, nr, nw); end
    tests++; if (mem_a[8] !== 32'hBEEFAA44) begin fails++; $display("FAIL busy_mem got %h exp beefaa44", mem_a[8]); end
    // Abandon a byte store in its WAIT cycle.
    @(negedge clk);
    sel = 0; we = 1; size = 2'b00; addr = 23'h20; wdata = 32'h77; req_a = 1'b1;
    @(posedge clk); #1 req_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL rst_pre_busy got %b exp 1", busy_a); end
    rst = 1'b1;
    #1;
    tests++; if ({rdata_a, wd_a} !== 64'h0) begin fails++; $display("FAIL rst_mid_data got %h exp 0", {rdata_a, wd_a}); end
    tests++; if ({ready_a, busy_a, mis_a, mw_a, mr_a, dira_a} !== 26'h0) begin fails++; $display("FAIL rst_mid_ctrl got %h exp 0", {ready_a, busy_a, mis_a, mw_a, mr_a, dira_a}); end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (mw_a) wr_seen = 1; end
    tests++; if ({wr_seen, mem_a[8]} !== {1'b0, 32'hBEEFAA44}) begin fails++; $display("FAIL rst_no_write got %b/%h exp 0/beefaa44", wr_seen, mem_a[8]); end
    do_req(0, 0, 0, 2'b10, 0, 23'h10, 32'h0, lat, nr, nw, wd, di, rd, m);
    tests++; if ({lat, rd} !== {32'd3, 32'hDEADBEEF}) begin fails++; $display("FAIL rst_after got lat=%0d %h exp 3/deadbeef", lat, rd); end
  endtask

  task automatic test_latency3();
    int lat, nr, nw; logic [31:0] wd, rd; logic [20:0] di; logic m;
    do_req(1, 0, 1, 2'b10, 0, 23'h14, 32'hCAFEF00D, lat, nr, nw, wd, di, rd, m);
    tests++; if (lat !== 2) begin fails++; $display("FAIL l3_wst_lat got %0d exp 2", lat); end
    do_req(1, 0, 0, 2'b10, 0, 23'h14, 32'h0, lat, nr, nw, wd, di, rd, m);
    tests++; if ({lat, rd} !== {32'd5, 32'hCAFEF00D}) begin fails++; $display("FAIL l3_load got lat=%0d %h exp 5/cafef00d", lat, rd); end
    do_req(1, 0, 1, 2'b00, 0, 23'h17, 32'h0000005A, lat, nr, nw, wd, di, rd, m);
    tests++; if ({lat, wd} !== {32'd6, 32'h5AFEF00D}) begin fails++; $display("FAIL l3_rmw got lat=%0d %h exp 6/5afef00d", lat, wd); end
    do_req(1, 0, 0, 2'b01, 1, 23'h16, 32'h0, lat, nr, nw, wd, di, rd, m);
    tests++; if ({lat, rd} !== {32'd5, 32'h00005AFE}) begin fails++; $display("FAIL l3_half got lat=%0d %h exp 5/00005afe", lat, rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_word();
    test_byte_rmw();
    test_signed();
    test_misalign();
    test_busy_reset();
    test_latency3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
